// File: rtl/kcounter_pkg.sv
// Shared helpers for the DPLL K counter family: modulus decode and centre value.
package kcounter_pkg;

  localparam int unsigned KMODE_DEFAULT = 2;

  // Terminal value 2^(k+2)-1, clamped to all ones of the counter width.
  function automatic logic [31:0] ktop_of(input int unsigned k, input int unsigned width);
    logic [32:0] t;
    if (k + 2 >= width) t = (33'd1 << width) - 33'd1;
    else                t = (33'd1 << (k + 2)) - 33'd1;
    return t[31:0];
  endfunction

  // Centre value (Ktop+1)>>1, computed one bit wider so all-ones does not overflow.
  function automatic logic [31:0] kmid_of(input logic [31:0] ktop);
    logic [32:0] t;
    t = ({1'b0, ktop} + 33'd1) >> 1;
    return t[31:0];
  endfunction

endpackage

// File: rtl/kcounter_param_if.sv
// Control/status bundle between the phase detector, K counter and I/D controller.
interface kcounter_param_if #(
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned KMODE_W = 4,
  parameter int unsigned SLIP_W  = 8
);
  logic                     enable;
  logic                     dnup;
  logic [KMODE_W-1:0]       Kmode;
  logic                     mode_load;
  logic                     slip_clr;
  logic                     carry;
  logic                     borrow;
  logic [WIDTH-1:0]         count;
  logic [WIDTH-1:0]         ktop;
  logic signed [SLIP_W-1:0] slip;

  modport master (
    output enable, dnup, Kmode, mode_load, slip_clr,
    input  carry, borrow, count, ktop, slip
  );

  modport slave (
    input  enable, dnup, Kmode, mode_load, slip_clr,
    output carry, borrow, count, ktop, slip
  );
endinterface

// File: rtl/kcounter_param_slip_acc.sv
// Saturating signed up/down accumulator with synchronous clear (clear dominates).
module slip_acc #(
  parameter int unsigned W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                dec,
  input  logic                clr,
  output logic signed [W-1:0] acc
);
  localparam logic signed [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0] acc_q;
  logic signed [W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr)                                   acc_d = '0;
    else if (inc && !dec && acc_q != ACC_MAX)  acc_d = acc_q + W'(1);
    else if (dec && !inc && acc_q != ACC_MIN)  acc_d = acc_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

// File: rtl/kcounter_param.sv
// Parametrised up/down K counter with run-time modulus reload, registered
// carry/borrow pulses and a saturating slip monitor.
module kcounter_param
  import kcounter_pkg::*;
#(
  parameter int unsigned WIDTH         = 12,
  parameter int unsigned KMODE_W       = 4,
  parameter int unsigned DEFAULT_KMODE = KMODE_DEFAULT,
  parameter int unsigned CENTER        = 0,
  parameter int unsigned SLIP_W        = 8
) (
  input  logic            Kclock,
  input  logic            reset_n,
  kcounter_param_if.slave bus
);
  localparam logic [WIDTH-1:0] RST_KTOP  = WIDTH'(ktop_of(DEFAULT_KMODE, WIDTH));
  localparam logic [WIDTH-1:0] RST_KMID  = WIDTH'(kmid_of(ktop_of(DEFAULT_KMODE, WIDTH)));
  localparam logic [WIDTH-1:0] RST_COUNT = (CENTER != 0) ? RST_KMID : '0;

  logic [WIDTH-1:0]   ktop_q,  ktop_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               carry_q, carry_d;
  logic               borrow_q, borrow_d;
  logic [KMODE_W-1:0] k_eff;
  logic [WIDTH-1:0]   new_ktop, new_kmid, cur_kmid;
  logic [WIDTH-1:0]   wrap_up_val, wrap_dn_val;
  logic signed [SLIP_W-1:0] slip_w;

  // Mode load has priority over stepping and suppresses pulses in its cycle.
  always_comb begin
    k_eff       = (bus.Kmode == '0) ? KMODE_W'(DEFAULT_KMODE) : bus.Kmode;
    new_ktop    = WIDTH'(ktop_of(32'(k_eff), WIDTH));
    new_kmid    = WIDTH'(kmid_of(32'(new_ktop)));
    cur_kmid    = WIDTH'(kmid_of(32'(ktop_q)));
    wrap_up_val = (CENTER != 0) ? cur_kmid : '0;
    wrap_dn_val = (CENTER != 0) ? cur_kmid : ktop_q;

    ktop_d   = ktop_q;
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;

    if (bus.mode_load) begin
      ktop_d = new_ktop;
      if (count_q > new_ktop) count_d = new_kmid;
    end else if (bus.enable) begin
      if (!bus.dnup) begin
        if (count_q == ktop_q) begin
          count_d = wrap_up_val;
          carry_d = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d  = wrap_dn_val;
          borrow_d = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge Kclock or negedge reset_n) begin
    if (!reset_n) begin
      ktop_q   <= RST_KTOP;
      count_q  <= RST_COUNT;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      ktop_q   <= ktop_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  // Fed from the wrap decode so slip moves on the same edge the pulse rises.
  slip_acc #(.W(SLIP_W)) u_slip (
    .clk   (Kclock),
    .rst_n (reset_n),
    .inc   (carry_d),
    .dec   (borrow_d),
    .clr   (bus.slip_clr),
    .acc   (slip_w)
  );

  assign bus.ktop   = ktop_q;
  assign bus.count  = count_q;
  assign bus.carry  = carry_q;
  assign bus.borrow = borrow_q;
  assign bus.slip   = slip_w;
endmodule

// File: tb/tb_kcounter_param.sv
// Scoreboard bench for kcounter_param: legacy-wrap and centre-restart instances.
module tb_kcounter_param;

  typedef struct {
    string             name;
    logic [11:0]       count;
    logic [11:0]       ktop;
    logic              carry;
    logic              borrow;
    logic signed [7:0] slip;
  } exp_t;

  logic Kclock;
  logic reset_n;
  int   checks;
  int   errors;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  kcounter_param_if #(.WIDTH(12), .KMODE_W(4), .SLIP_W(8)) bus0 ();
  kcounter_param_if #(.WIDTH(12), .KMODE_W(4), .SLIP_W(8)) bus1 ();

  kcounter_param #(.WIDTH(12), .KMODE_W(4), .DEFAULT_KMODE(2), .CENTER(0), .SLIP_W(8)) dut0 (
    .Kclock (Kclock),
    .reset_n(reset_n),
    .bus    (bus0)
  );

  kcounter_param #(.WIDTH(12), .KMODE_W(4), .DEFAULT_KMODE(2), .CENTER(1), .SLIP_W(8)) dut1 (
    .Kclock (Kclock),
    .reset_n(reset_n),
    .bus    (bus1)
  );

  initial Kclock = 1'b0;
  always #5 Kclock = ~Kclock;

  function automatic exp_t mk(input string n, input int c, input int k,
                              input bit ca, input bit bo, input int s);
    exp_t e;
    e.name   = n;
    e.count  = 12'(c);
    e.ktop   = 12'(k);
    e.carry  = ca;
    e.borrow = bo;
    e.slip   = 8'(s);
    return e;
  endfunction

  task automatic chk(input int which, input exp_t e, input logic [11:0] c, input logic [11:0] k,
                     input logic ca, input logic bo, input logic signed [7:0] s);
    checks++;
    if (c !== e.count || k !== e.ktop || ca !== e.carry || bo !== e.borrow || s !== e.slip) begin
      errors++;
      $display("FAIL dut%0d %s: got count=%0d ktop=%0d carry=%b borrow=%b slip=%0d, want count=%0d ktop=%0d carry=%b borrow=%b slip=%0d",
               which, e.name, c, k, ca, bo, s, e.count, e.ktop, e.carry, e.borrow, e.slip);
    end
  endtask

  // Monitors: one expected entry per sampled cycle, checked on the falling edge.
  always @(negedge Kclock) begin
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      chk(0, e0, bus0.count, bus0.ktop, bus0.carry, bus0.borrow, bus0.slip);
    end
  end

  always @(negedge Kclock) begin
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      chk(1, e1, bus1.count, bus1.ktop, bus1.carry, bus1.borrow, bus1.slip);
    end
  end

  task automatic idle_all();
    bus0.enable = 1'b0; bus0.dnup = 1'b0; bus0.Kmode = 4'd0; bus0.mode_load = 1'b0; bus0.slip_clr = 1'b0;
    bus1.enable = 1'b0; bus1.dnup = 1'b0; bus1.Kmode = 4'd0; bus1.mode_load = 1'b0; bus1.slip_clr = 1'b0;
  endtask

  // Drive one cycle of stimulus on one instance and queue the post-edge expectation.
  task automatic drv(input int which, input logic en, input logic dn, input logic ld,
                     input logic [3:0] km, input logic clr, input exp_t e);
    if (which == 0) begin
      bus0.enable = en; bus0.dnup = dn; bus0.mode_load = ld; bus0.Kmode = km; bus0.slip_clr = clr;
    end else begin
      bus1.enable = en; bus1.dnup = dn; bus1.mode_load = ld; bus1.Kmode = km; bus1.slip_clr = clr;
    end
    @(posedge Kclock);
    if (which == 0) q0.push_back(e);
    else            q1.push_back(e);
    #1;
    idle_all();
  endtask

  initial begin
    int c;
    int s;
    int n;
    bit ca;
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    idle_all();

    // Reset state of both instances.
    @(posedge Kclock); #1;
    q0.push_back(mk("reset", 0, 15, 0, 0, 0));
    q1.push_back(mk("reset", 8, 15, 0, 0, 0));
    @(posedge Kclock); #1;
    reset_n = 1'b1;

    // Legacy wrap: 16 up steps, carry on the 16th.
    for (int i = 0; i < 16; i++)
      drv(0, 1, 0, 0, 4'd0, 0, mk("up_wrap", (i + 1) % 16, 15, i == 15, 0, (i == 15) ? 1 : 0));
    drv(0, 0, 0, 0, 4'd0, 0, mk("carry_drop", 0, 15, 0, 0, 1));
    drv(0, 1, 1, 0, 4'd0, 0, mk("down_wrap", 15, 15, 0, 1, 0));
    drv(0, 0, 1, 0, 4'd0, 0, mk("borrow_drop", 15, 15, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      drv(0, 1, 1, 0, 4'd0, 0, mk("down_to_12", 14 - i, 15, 0, 0, 0));

    // Mode reloads: count 12 > 7 forces Kmid; loads never step.
    drv(0, 1, 0, 1, 4'd1,  0, mk("load_k1", 4, 7, 0, 0, 0));
    drv(0, 1, 1, 1, 4'd0,  0, mk("load_k0", 4, 15, 0, 0, 0));
    drv(0, 1, 0, 1, 4'd15, 0, mk("load_k15", 4, 4095, 0, 0, 0));
    drv(0, 0, 0, 1, 4'd0,  0, mk("load_k0b", 4, 15, 0, 0, 0));
    drv(0, 0, 0, 0, 4'd0,  0, mk("hold", 4, 15, 0, 0, 0));
    drv(0, 0, 0, 1, 4'd1,  0, mk("load_keep", 4, 7, 0, 0, 0));

    // 130 carries with Ktop=7: slip saturates at +127.
    c = 4; s = 0; n = 0;
    while (n < 130) begin
      ca = (c == 7);
      if (ca) begin
        c = 0; n++;
        if (s < 127) s++;
      end else begin
        c++;
      end
      drv(0, 1, 0, 0, 4'd0, 0, mk("sat_up", c, 7, ca, 0, s));
    end
    drv(0, 1, 1, 0, 4'd0, 1, mk("clr_borrow", 7, 7, 0, 1, 0));
    drv(0, 1, 1, 0, 4'd0, 0, mk("after_clr", 6, 7, 0, 0, 0));
    for (int i = 5; i >= 0; i--)
      drv(0, 1, 1, 0, 4'd0, 0, mk("down_run", i, 7, 0, 0, 0));
    drv(0, 1, 1, 0, 4'd0, 0, mk("neg_slip", 7, 7, 0, 1, -1));

    // Centre restart: load Kmode=1 pulls count 8 down to Kmid 4.
    drv(1, 0, 0, 1, 4'd1, 0, mk("c_load", 4, 7, 0, 0, 0));
    for (int i = 5; i <= 7; i++)
      drv(1, 1, 0, 0, 4'd0, 0, mk("c_up", i, 7, 0, 0, 0));
    drv(1, 1, 0, 0, 4'd0, 0, mk("c_carry", 4, 7, 1, 0, 1));
    drv(1, 0, 0, 0, 4'd0, 0, mk("c_hold", 4, 7, 0, 0, 1));
    for (int i = 3; i >= 0; i--)
      drv(1, 1, 1, 0, 4'd0, 0, mk("c_down", i, 7, 0, 0, 1));
    drv(1, 1, 1, 0, 4'd0, 0, mk("c_borrow", 4, 7, 0, 1, 0));

    // Asynchronous reset mid-operation.
    @(negedge Kclock); #1;
    reset_n = 1'b0;
    q0.push_back(mk("async_reset", 0, 15, 0, 0, 0));
    q1.push_back(mk("async_reset", 8, 15, 0, 0, 0));
    @(negedge Kclock); #1;
    @(posedge Kclock); #1;
    reset_n = 1'b1;
    drv(0, 1, 0, 0, 4'd0, 0, mk("post_reset_step", 1, 15, 0, 0, 0));

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && (q0.size() > 0 || q1.size() > 0); i++)
      @(negedge Kclock);
    #1;
    if (q0.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, want 0", q0.size(), q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
